// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection,
// flush/hold priority handling and a saturating count of injected bubbles.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  EX_in,
    input  logic [2:0]  M_in,
    input  logic [1:0]  WB_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [31:0] imm_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    input  logic        hold,
    output logic [2:0]  EX_out,
    output logic [2:0]  M_out,
    output logic [1:0]  WB_out,
    output logic [31:0] pc4_out,
    output logic [31:0] rd1_out,
    output logic [31:0] rd2_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [4:0]  rd_out,
    output logic        valid_out,
    output logic        stall,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        UPD_LOAD   = 2'd0,
        UPD_BUBBLE = 2'd1,
        UPD_FLUSH  = 2'd2,
        UPD_HOLD   = 2'd3
    } upd_t;

    logic [2:0]  ex_r, m_r;
    logic [1:0]  wb_r;
    logic [31:0] pc4_r, rd1_r, rd2_r, imm_r;
    logic [4:0]  rs_r, rt_r, rd_r;
    logic        valid_r;
    logic [15:0] bubble_cnt_r;
    logic        stall_s;
    upd_t        mode_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Load-use hazard: a valid load in EX whose target is read by the ID instruction
    always_comb begin
        stall_s = 1'b0;
        if (valid_r && m_r[1] && (rt_r != 5'd0) &&
            ((rt_r == rs_in) || (rt_r == rt_in)) && !hold && !flush) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    // Update selection: flush beats hold, hold beats the hazard bubble
    always_comb begin
        mode_s = UPD_LOAD;
        if (flush) begin
            mode_s = UPD_FLUSH;
        end else if (hold) begin
            mode_s = UPD_HOLD;
        end else if (stall_s) begin
            mode_s = UPD_BUBBLE;
        end else begin
            mode_s = UPD_LOAD;
        end
    end

    // Control bundles, valid flag and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_r         <= 3'd0;
            m_r          <= 3'd0;
            wb_r         <= 2'd0;
            valid_r      <= 1'b0;
            bubble_cnt_r <= 16'd0;
        end else begin
            case (mode_s)
                UPD_LOAD: begin
                    ex_r    <= EX_in;
                    m_r     <= M_in;
                    wb_r    <= WB_in;
                    valid_r <= 1'b1;
                end
                UPD_BUBBLE: begin
                    ex_r         <= 3'd0;
                    m_r          <= 3'd0;
                    wb_r         <= 2'd0;
                    valid_r      <= 1'b0;
                    bubble_cnt_r <= sat_inc(bubble_cnt_r);
                end
                UPD_FLUSH: begin
                    ex_r    <= 3'd0;
                    m_r     <= 3'd0;
                    wb_r    <= 2'd0;
                    valid_r <= 1'b0;
                end
                UPD_HOLD: begin
                    ex_r    <= ex_r;
                    m_r     <= m_r;
                    wb_r    <= wb_r;
                    valid_r <= valid_r;
                end
                default: begin
                    ex_r    <= 3'd0;
                    m_r     <= 3'd0;
                    wb_r    <= 2'd0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Operands and specifiers load on every non-hold edge, even into a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            pc4_r <= 32'd0;
            rd1_r <= 32'd0;
            rd2_r <= 32'd0;
            imm_r <= 32'd0;
            rs_r  <= 5'd0;
            rt_r  <= 5'd0;
            rd_r  <= 5'd0;
        end else if (mode_s != UPD_HOLD) begin
            pc4_r <= pc4_in;
            rd1_r <= rd1_in;
            rd2_r <= rd2_in;
            imm_r <= imm_in;
            rs_r  <= rs_in;
            rt_r  <= rt_in;
            rd_r  <= rd_in;
        end else begin
            pc4_r <= pc4_r;
            rd1_r <= rd1_r;
            rd2_r <= rd2_r;
            imm_r <= imm_r;
            rs_r  <= rs_r;
            rt_r  <= rt_r;
            rd_r  <= rd_r;
        end
    end

    assign EX_out     = ex_r;
    assign M_out      = m_r;
    assign WB_out     = wb_r;
    assign pc4_out    = pc4_r;
    assign rd1_out    = rd1_r;
    assign rd2_out    = rd2_r;
    assign imm_out    = imm_r;
    assign rs_out     = rs_r;
    assign rt_out     = rt_r;
    assign rd_out     = rd_r;
    assign valid_out  = valid_r;
    assign stall      = stall_s;
    assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: one vector per clock edge,
// followed by a long saturation run of the bubble counter.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  EX_in, M_in;
    logic [1:0]  WB_in;
    logic [31:0] pc4_in, rd1_in, rd2_in, imm_in;
    logic [4:0]  rs_in, rt_in, rd_in;
    logic        flush, hold;
    logic [2:0]  EX_out, M_out;
    logic [1:0]  WB_out;
    logic [31:0] pc4_out, rd1_out, rd2_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        valid_out, stall;
    logic [15:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .EX_in(EX_in), .M_in(M_in), .WB_in(WB_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .flush(flush), .hold(hold),
        .EX_out(EX_out), .M_out(M_out), .WB_out(WB_out),
        .pc4_out(pc4_out), .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .valid_out(valid_out), .stall(stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmode: 0 = data fields expected zero, 1 = loaded from this vector, 2 = unchanged
    typedef struct {
        logic        rst;
        logic [2:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rs, rt, rd;
        logic [31:0] base;
        logic        flush, hold;
        logic        chk_stall;
        logic        exp_stall;
        logic [2:0]  exp_ex, exp_m;
        logic [1:0]  exp_wb;
        logic        exp_valid;
        logic [15:0] exp_cnt;
        logic [1:0]  dmode;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [2:0] ex, input logic [2:0] m,
                                input logic [1:0] wb, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] base,
                                input logic fl, input logic hd, input logic cs, input logic es,
                                input logic [2:0] eex, input logic [2:0] em, input logic [1:0] ewb,
                                input logic ev, input logic [15:0] ec, input logic [1:0] dm);
        vec_t v;
        v.rst = r; v.ex = ex; v.m = m; v.wb = wb; v.rs = rs; v.rt = rt; v.rd = rd;
        v.base = base; v.flush = fl; v.hold = hd; v.chk_stall = cs; v.exp_stall = es;
        v.exp_ex = eex; v.exp_m = em; v.exp_wb = ewb; v.exp_valid = ev; v.exp_cnt = ec;
        v.dmode = dm;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst    = v.rst;
        EX_in  = v.ex;
        M_in   = v.m;
        WB_in  = v.wb;
        rs_in  = v.rs;
        rt_in  = v.rt;
        rd_in  = v.rd;
        rd1_in = v.base;
        pc4_in = v.base + 32'd4;
        rd2_in = v.base ^ 32'h0F0F_0F0F;
        imm_in = ~v.base;
        flush  = v.flush;
        hold   = v.hold;
    endtask

    logic [31:0] e_pc4, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rs, e_rt, e_rd;

    initial begin
        //           rst ex      m       wb     rs     rt     rd     base          fl    hd    cs    es    eex     em      ewb    ev    cnt     dm
        vecs[0]  = mk(1'b1, 3'b111, 3'b111, 2'b11, 5'd1, 5'd2, 5'd3, 32'hDEAD0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 16'd0, 2'd0);
        vecs[1]  = mk(1'b1, 3'b111, 3'b111, 2'b11, 5'd1, 5'd2, 5'd3, 32'hDEAD0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 16'd0, 2'd0);
        vecs[2]  = mk(1'b0, 3'b110, 3'b000, 2'b10, 5'd1, 5'd2, 5'd3, 32'h00001234, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 3'b000, 2'b10, 1'b1, 16'd0, 2'd1);
        // lw $5, then a consumer of $5 in rs: one bubble, then the consumer loads
        vecs[3]  = mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0, 32'h00000100, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd0, 2'd1);
        vecs[4]  = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 32'h00000200, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 16'd1, 2'd1);
        vecs[5]  = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 32'h00000200, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 2'b10, 1'b1, 16'd1, 2'd1);
        // lw $0 followed by a reader of $0: no hazard
        vecs[6]  = mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd3, 5'd0, 5'd0, 32'h00000300, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd1);
        vecs[7]  = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd0, 5'd0, 5'd9, 32'h00000400, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 2'b10, 1'b1, 16'd1, 2'd1);
        // non-load writing $5 followed by a reader of $5: no hazard
        vecs[8]  = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd1, 5'd5, 5'd2, 32'h00000500, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 2'b10, 1'b1, 16'd1, 2'd1);
        vecs[9]  = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd4, 32'h00000600, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 2'b10, 1'b1, 16'd1, 2'd1);
        // lw $7 then rt-match consumer with flush: flush wins, no bubble counted
        vecs[10] = mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd2, 5'd7, 5'd0, 32'h00000700, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd1);
        vecs[11] = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd1, 5'd7, 5'd8, 32'h00000800, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 16'd1, 2'd1);
        // lw $9, then three hold cycles with a pending hazard, then release
        vecs[12] = mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd1, 5'd9, 5'd0, 32'h00000900, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd1);
        vecs[13] = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd9, 5'd4, 5'd5, 32'h00000A00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd2);
        vecs[14] = mk(1'b0, 3'b101, 3'b001, 2'b01, 5'd3, 5'd9, 5'd6, 32'h00000B00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd2);
        vecs[15] = mk(1'b0, 3'b110, 3'b100, 2'b10, 5'd9, 5'd1, 5'd2, 32'h00000C00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd1, 2'd2);
        vecs[16] = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd9, 5'd4, 5'd5, 32'h00000D00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 16'd2, 2'd1);
        vecs[17] = mk(1'b0, 3'b100, 3'b000, 2'b10, 5'd9, 5'd4, 5'd5, 32'h00000D00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 2'b10, 1'b1, 16'd2, 2'd1);
        // lw $5 then rst during the stall: register and counter clear
        vecs[18] = mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd1, 5'd5, 5'd0, 32'h00000E00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b011, 3'b010, 2'b11, 1'b1, 16'd2, 2'd1);
        vecs[19] = mk(1'b1, 3'b100, 3'b000, 2'b10, 5'd5, 5'd6, 5'd7, 32'h00000F00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 16'd0, 2'd0);
        vecs[20] = mk(1'b0, 3'b110, 3'b000, 2'b10, 5'd5, 5'd5, 5'd1, 32'h00001234, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 3'b000, 2'b10, 1'b1, 16'd0, 2'd1);

        drive(vecs[0]);
        e_pc4 = 32'd0; e_rd1 = 32'd0; e_rd2 = 32'd0; e_imm = 32'd0;
        e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            if (vecs[i].chk_stall) chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].exp_stall});
            @(posedge clk);
            #1;
            if (vecs[i].dmode == 2'd0) begin
                e_pc4 = 32'd0; e_rd1 = 32'd0; e_rd2 = 32'd0; e_imm = 32'd0;
                e_rs = 5'd0; e_rt = 5'd0; e_rd = 5'd0;
            end else if (vecs[i].dmode == 2'd1) begin
                e_rd1 = vecs[i].base;
                e_pc4 = vecs[i].base + 32'd4;
                e_rd2 = vecs[i].base ^ 32'h0F0F_0F0F;
                e_imm = ~vecs[i].base;
                e_rs = vecs[i].rs; e_rt = vecs[i].rt; e_rd = vecs[i].rd;
            end
            chk($sformatf("v%0d EX_out", i), {29'd0, EX_out}, {29'd0, vecs[i].exp_ex});
            chk($sformatf("v%0d M_out", i), {29'd0, M_out}, {29'd0, vecs[i].exp_m});
            chk($sformatf("v%0d WB_out", i), {30'd0, WB_out}, {30'd0, vecs[i].exp_wb});
            chk($sformatf("v%0d valid_out", i), {31'd0, valid_out}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d bubble_cnt", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].exp_cnt});
            chk($sformatf("v%0d pc4_out", i), pc4_out, e_pc4);
            chk($sformatf("v%0d rd1_out", i), rd1_out, e_rd1);
            chk($sformatf("v%0d rd2_out", i), rd2_out, e_rd2);
            chk($sformatf("v%0d imm_out", i), imm_out, e_imm);
            chk($sformatf("v%0d rs/rt/rd", i), {17'd0, rs_out, rt_out, rd_out}, {17'd0, e_rs, e_rt, e_rd});
            #1;
            chk($sformatf("v%0d stall after edge", i), {31'd0, stall},
                {31'd0, (vecs[i].exp_valid && vecs[i].exp_m[1] && (e_rt != 5'd0) &&
                         ((e_rt == rs_in) || (e_rt == rt_in)) && !hold && !flush)});
        end

        // Saturation: lw $5 reading $5 held in ID alternates load / bubble forever
        begin
            int n;
            int cyc;
            n = 0;
            cyc = 0;
            @(negedge clk);
            drive(mk(1'b0, 3'b011, 3'b010, 2'b11, 5'd5, 5'd5, 5'd1, 32'h0000_5A5A, 1'b0, 1'b0,
                     1'b0, 1'b0, 3'b000, 3'b000, 2'b00, 1'b0, 16'd0, 2'd0));
            while (n < 65540 && cyc < 140000) begin
                @(negedge clk);
                cyc++;
                if (stall) begin
                    n++;
                    @(posedge clk);
                    #1;
                    if (n == 1 || n == 65534 || n == 65535 || n == 65536 || n == 65540) begin
                        chk($sformatf("sat bubble_cnt after %0d bubbles", n), {16'd0, bubble_cnt},
                            (n >= 65535) ? 32'h0000_FFFF : n);
                        chk($sformatf("sat bubble valid after %0d", n), {31'd0, valid_out}, 32'd0);
                    end
                end
            end
            chk("sat bubble count reached", n, 32'd65540);
            @(negedge clk);
            chk("sat cnt after extra cycle", {16'd0, bubble_cnt}, 32'h0000_FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
